single_cycle_mips_cpu: RTL and testbench

Single-cycle 32-bit MIPS processor core. It fetches one instruction per clock from an external word-addressed instruction memory, executes it, and commits the result in the same cycle. Results go to an internal register file and/or an external word-addressed data memory. It is the top of the CPU datapath; the instruction and data memories are separate blocks outside it.

---
 rtl/single_cycle_mips_cpu.sv | 143 ++++++++++++++
 tb/tb_single_cycle_mips_cpu.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_cycle_mips_cpu.sv
// Single-cycle 32-bit MIPS core: fetch, decode, execute and commit in one clock.
// Instruction and data memories sit outside; both are word-addressed.
module single_cycle_mips_cpu #(
  parameter int unsigned bit_size = 32,
  parameter int unsigned mem_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic [mem_size-1:0] IM_Address,
  input  logic [bit_size-1:0] Instruction,
  output logic [mem_size-1:0] DM_Address,
  output logic                DM_enable,
  output logic [bit_size-1:0] DM_Write_Data,
  input  logic [bit_size-1:0] DM_Read_Data
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_SLTI  = 6'h0A,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL = 6'h00,
    FN_SRL = 6'h02,
    FN_JR  = 6'h08,
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_SLT = 6'h2A
  } funct_e;

  logic [31:0]         pc;
  logic [31:0]         pc_plus4;
  logic [31:0]         branch_target;
  logic [31:0]         jump_target;
  logic [31:0]         next_pc;
  logic [bit_size-1:0] regs [32];

  opcode_e             opcode;
  funct_e              funct;
  logic [4:0]          rs_idx;
  logic [4:0]          rt_idx;
  logic [4:0]          rd_idx;
  logic [4:0]          shamt;
  logic [bit_size-1:0] rs_val;
  logic [bit_size-1:0] rt_val;
  logic [bit_size-1:0] simm;
  logic [bit_size-1:0] zimm;

  logic                wr_en;
  logic [4:0]          wr_idx;
  logic [bit_size-1:0] wr_data;
  logic                dm_we;

  assign opcode = opcode_e'(Instruction[31:26]);
  assign funct  = funct_e'(Instruction[5:0]);
  assign rs_idx = Instruction[25:21];
  assign rt_idx = Instruction[20:16];
  assign rd_idx = Instruction[15:11];
  assign shamt  = Instruction[10:6];
  assign simm   = {{(bit_size-16){Instruction[15]}}, Instruction[15:0]};
  assign zimm   = {{(bit_size-16){1'b0}}, Instruction[15:0]};

  // $0 is hardwired to zero on the read side; writes to it are also dropped.
  assign rs_val = (rs_idx == 5'd0) ? '0 : regs[rs_idx];
  assign rt_val = (rt_idx == 5'd0) ? '0 : regs[rt_idx];

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {{14{Instruction[15]}}, Instruction[15:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], Instruction[25:0], 2'b00};

  assign IM_Address    = mem_size'(pc >> 2);
  assign DM_Address    = mem_size'((rs_val + simm) >> 2);
  assign DM_Write_Data = rt_val;
  assign DM_enable     = dm_we & rst;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = rt_idx;
    wr_data = '0;
    dm_we   = 1'b0;
    next_pc = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        wr_idx = rd_idx;
        case (funct)
          FN_ADD: begin wr_en = 1'b1; wr_data = rs_val + rt_val; end
          FN_SUB: begin wr_en = 1'b1; wr_data = rs_val - rt_val; end
          FN_AND: begin wr_en = 1'b1; wr_data = rs_val & rt_val; end
          FN_OR:  begin wr_en = 1'b1; wr_data = rs_val | rt_val; end
          FN_SLT: begin
            wr_en   = 1'b1;
            wr_data = {{(bit_size-1){1'b0}}, ($signed(rs_val) < $signed(rt_val))};
          end
          FN_SLL: begin wr_en = 1'b1; wr_data = rt_val << shamt; end
          FN_SRL: begin wr_en = 1'b1; wr_data = rt_val >> shamt; end
          FN_JR:  next_pc = 32'(rs_val);
          default: ;
        endcase
      end
      OP_ADDI: begin wr_en = 1'b1; wr_data = rs_val + simm; end
      OP_ANDI: begin wr_en = 1'b1; wr_data = rs_val & zimm; end
      OP_ORI:  begin wr_en = 1'b1; wr_data = rs_val | zimm; end
      OP_SLTI: begin
        wr_en   = 1'b1;
        wr_data = {{(bit_size-1){1'b0}}, ($signed(rs_val) < $signed(simm))};
      end
      OP_LW:   begin wr_en = 1'b1; wr_data = DM_Read_Data; end
      OP_SW:   dm_we = 1'b1;
      OP_BEQ:  if (rs_val == rt_val) next_pc = branch_target;
      OP_BNE:  if (rs_val != rt_val) next_pc = branch_target;
      OP_J:    next_pc = jump_target;
      OP_JAL: begin
        next_pc = jump_target;
        wr_en   = 1'b1;
        wr_idx  = 5'd31;
        wr_data = bit_size'(pc_plus4);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (wr_en && (wr_idx != 5'd0)) regs[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_single_cycle_mips_cpu.sv
// Bench for single_cycle_mips_cpu: directed program with a store-result table,
// plus random programs checked cycle by cycle against an instruction-level model.
module tb_single_cycle_mips_cpu;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic [15:0] IM_Address;
  logic [31:0] Instruction;
  logic [15:0] DM_Address;
  logic        DM_enable;
  logic [31:0] DM_Write_Data;
  logic [31:0] DM_Read_Data;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];

  // instruction-level reference state
  logic [31:0] mpc;
  logic [31:0] mreg [32];
  logic [31:0] mdm  [256];

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned trace [$];

  typedef struct {
    int unsigned word;
    logic [31:0] exp;
  } dm_vec_t;
  dm_vec_t dm_vecs [$];

  single_cycle_mips_cpu #(.bit_size(32), .mem_size(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .IM_Address   (IM_Address),
    .Instruction  (Instruction),
    .DM_Address   (DM_Address),
    .DM_enable    (DM_enable),
    .DM_Write_Data(DM_Write_Data),
    .DM_Read_Data (DM_Read_Data)
  );

  always #5 clk = ~clk;

  assign Instruction  = (IM_Address < 16'd256) ? imem[IM_Address[7:0]] : 32'h0;
  assign DM_Read_Data = (DM_Address < 16'd256) ? dmem[DM_Address[7:0]] : 32'h0;

  always @(posedge clk)
    if (DM_enable === 1'b1 && DM_Address < 16'd256) dmem[DM_Address[7:0]] <= DM_Write_Data;

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    mpc = 32'h0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    for (int i = 0; i < 256; i++) begin mdm[i] = 32'h0; dmem[i] = 32'h0; end
  endtask

  // Executes one instruction of the model and checks the DUT's outputs for it.
  task automatic model_cycle(input int unsigned cyc);
    logic [31:0] ins, a, b, simm, zimm, npc, wd, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, dst;
    logic        wr, we;
    ins  = (mpc[31:2] < 256) ? imem[mpc[9:2]] : 32'h0;
    op   = ins[31:26]; fn = ins[5:0];
    rs   = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
    a    = mreg[rs];   b  = mreg[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    ea   = a + simm;
    npc  = mpc + 32'd4;
    wr = 1'b0; we = 1'b0; dst = rt; wd = 32'h0;
    case (op)
      6'h00: begin
        dst = rd; wr = 1'b1;
        case (fn)
          6'h20: wd = a + b;
          6'h22: wd = a - b;
          6'h24: wd = a & b;
          6'h25: wd = a | b;
          6'h2A: wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: wd = b << sh;
          6'h02: wd = b >> sh;
          6'h08: begin wr = 1'b0; npc = a; end
          default: wr = 1'b0;
        endcase
      end
      6'h08: begin wr = 1'b1; wd = a + simm; end
      6'h0C: begin wr = 1'b1; wd = a & zimm; end
      6'h0D: begin wr = 1'b1; wd = a | zimm; end
      6'h0A: begin wr = 1'b1; wd = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; end
      6'h23: begin wr = 1'b1; wd = (ea[17:2] < 256) ? mdm[ea[9:2]] : 32'h0; end
      6'h2B: we = 1'b1;
      6'h04: if (a == b) npc = mpc + 32'd4 + (simm << 2);
      6'h05: if (a != b) npc = mpc + 32'd4 + (simm << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin
        wr = 1'b1; dst = 5'd31; wd = mpc + 32'd4;
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      default: ;
    endcase
    chk($sformatf("im_address@%0d", cyc), 32'(IM_Address), {16'h0, mpc[17:2]});
    chk($sformatf("dm_enable@%0d", cyc), 32'(DM_enable), 32'(we));
    if (we) begin
      chk($sformatf("dm_address@%0d", cyc), 32'(DM_Address), {16'h0, ea[17:2]});
      chk($sformatf("dm_write_data@%0d", cyc), DM_Write_Data, b);
      if (ea[17:2] < 256) mdm[ea[9:2]] = b;
    end
    if (wr && dst != 5'd0) mreg[dst] = wd;
    mpc = npc;
  endtask

  task automatic run_lockstep(input int unsigned cycles);
    for (int unsigned c = 0; c < cycles; c++) begin
      trace.push_back(32'(IM_Address));
      model_cycle(c);
      @(negedge clk); #1;
    end
  endtask

  task automatic check_follow(input string name, input int unsigned from, input int unsigned to);
    bit found = 1'b0;
    for (int i = 0; i + 1 < trace.size(); i++) begin
      if (trace[i] == from) begin
        found = 1'b1;
        chk(name, trace[i+1], to);
        break;
      end
    end
    if (!found) begin
      checks++;
      $display("FAIL %s: word %0d never fetched, required successor %0d", name, from, to);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_reset_im_address", 32'(IM_Address), 32'h0);
    chk("async_reset_dm_enable", 32'(DM_enable), 32'h0);
    @(posedge clk); #1;
    chk("reset_hold_im_address", 32'(IM_Address), 32'h0);
  endtask

  task automatic load_directed();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[2]  = enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
    imem[3]  = enc_r(6'h22, 5'd1, 5'd2, 5'd4, 5'd0);
    imem[4]  = enc_r(6'h24, 5'd1, 5'd2, 5'd5, 5'd0);
    imem[5]  = enc_r(6'h25, 5'd1, 5'd2, 5'd6, 5'd0);
    imem[6]  = enc_r(6'h2A, 5'd1, 5'd2, 5'd7, 5'd0);
    imem[7]  = enc_r(6'h00, 5'd0, 5'd1, 5'd8, 5'd2);
    imem[8]  = enc_r(6'h02, 5'd0, 5'd2, 5'd9, 5'd1);
    for (int k = 1; k <= 9; k++)
      imem[8+k] = enc_i(6'h2B, 5'd0, 5'(k), 16'(4*(k-1)));
    imem[18] = enc_i(6'h08, 5'd0, 5'd10, 16'h1234);
    imem[19] = enc_i(6'h2B, 5'd0, 5'd10, 16'd40);
    imem[20] = enc_i(6'h23, 5'd0, 5'd11, 16'd40);
    imem[21] = enc_i(6'h0C, 5'd11, 5'd12, 16'h00FF);
    imem[22] = enc_i(6'h0D, 5'd11, 5'd13, 16'hF000);
    imem[23] = enc_i(6'h0A, 5'd2, 5'd14, 16'd0);
    imem[24] = enc_i(6'h2B, 5'd0, 5'd11, 16'd44);
    imem[25] = enc_i(6'h2B, 5'd0, 5'd12, 16'd48);
    imem[26] = enc_i(6'h2B, 5'd0, 5'd13, 16'd52);
    imem[27] = enc_i(6'h2B, 5'd0, 5'd14, 16'd56);
    imem[28] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    imem[29] = enc_i(6'h2B, 5'd0, 5'd0, 16'd60);
    imem[30] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    imem[31] = enc_i(6'h2B, 5'd0, 5'd1, 16'd64);
    imem[32] = enc_i(6'h2B, 5'd0, 5'd1, 16'd68);
    imem[33] = enc_i(6'h05, 5'd1, 5'd1, 16'd5);
    imem[34] = enc_i(6'h08, 5'd0, 5'd15, 16'h0055);
    imem[35] = enc_i(6'h2B, 5'd0, 5'd15, 16'd72);
    imem[36] = enc_i(6'h05, 5'd1, 5'd2, 16'd1);
    imem[37] = enc_i(6'h2B, 5'd0, 5'd1, 16'd76);
    imem[38] = enc_i(6'h04, 5'd1, 5'd2, 16'd1);
    imem[39] = enc_i(6'h2B, 5'd0, 5'd2, 16'd80);
    imem[40] = 32'hFC00_0000;
    imem[41] = enc_r(6'h3F, 5'd1, 5'd1, 5'd1, 5'd0);
    imem[42] = enc_i(6'h2B, 5'd0, 5'd1, 16'd84);
    imem[43] = enc_r(6'h20, 5'd1, 5'd1, 5'd1, 5'd0);
    imem[44] = enc_j(6'h03, 26'd51);
    imem[45] = enc_i(6'h2B, 5'd0, 5'd31, 16'd88);
    imem[46] = enc_i(6'h2B, 5'd0, 5'd1, 16'd92);
    imem[47] = enc_i(6'h2B, 5'd0, 5'd16, 16'd96);
    imem[48] = enc_j(6'h02, 26'd48);
    imem[51] = enc_i(6'h08, 5'd0, 5'd16, 16'h0077);
    imem[52] = enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic gen_random(input int unsigned n);
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int unsigned i = 0; i < n; i++) begin
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      int unsigned room, off;
      rs   = 5'($urandom_range(0, 7));
      rt   = 5'($urandom_range(0, 7));
      rd   = 5'($urandom_range(0, 7));
      imm  = 16'($urandom);
      room = n - 1 - i;
      case ($urandom_range(0, 12))
        0:  imem[i] = enc_i(6'h08, rs, rt, imm);
        1:  imem[i] = enc_i(6'h0C, rs, rt, imm);
        2:  imem[i] = enc_i(6'h0D, rs, rt, imm);
        3:  imem[i] = enc_i(6'h0A, rs, rt, imm);
        4:  imem[i] = enc_r(fns[$urandom_range(0, 4)], rs, rt, rd, 5'd0);
        5:  imem[i] = enc_r(($urandom_range(0, 1) != 0) ? 6'h02 : 6'h00, 5'd0, rt, rd,
                            5'($urandom_range(0, 31)));
        6:  imem[i] = enc_i(6'h23, 5'd0, rt, 16'(4 * $urandom_range(0, 31)));
        7:  imem[i] = enc_i(6'h2B, 5'd0, rt, 16'(4 * $urandom_range(0, 31)));
        8, 9: begin
          off = $urandom_range(0, (room < 3) ? room : 3);
          imem[i] = enc_i(($urandom_range(0, 1) != 0) ? 6'h05 : 6'h04, rs, rt, 16'(off));
        end
        10: imem[i] = {6'h3F, 26'($urandom)};
        11: imem[i] = enc_r(6'h3F, rs, rt, rd, 5'd0);
        default: begin
          off = $urandom_range(0, (room < 2) ? room : 2);
          imem[i] = enc_j(6'h03, 26'(i + 1 + off));
        end
      endcase
    end
    imem[n] = enc_j(6'h02, 26'(n));
  endtask

  initial begin
    int unsigned mx;
    dm_vecs = '{
      '{0, 32'd5},          '{1, 32'hFFFF_FFFD}, '{2, 32'd2},          '{3, 32'd8},
      '{4, 32'd5},          '{5, 32'hFFFF_FFFD}, '{6, 32'd0},          '{7, 32'h14},
      '{8, 32'h7FFF_FFFE},  '{10, 32'h1234},     '{11, 32'h1234},      '{12, 32'h34},
      '{13, 32'hF234},      '{14, 32'd1},        '{15, 32'd0},         '{16, 32'd0},
      '{17, 32'd0},         '{18, 32'h55},       '{19, 32'd0},         '{20, 32'hFFFF_FFFD},
      '{21, 32'd5},         '{22, 32'd180},      '{23, 32'd10},        '{24, 32'h77}
    };

    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin imem[i] = 32'h0; dmem[i] = 32'h0; end
    imem[0] = enc_i(6'h2B, 5'd0, 5'd0, 16'd0);

    // reset held across the edge at t=10; sw at word 0 must not strobe
    #2;  chk("reset_im_address_t2", 32'(IM_Address), 32'h0);
         chk("reset_dm_enable_t2", 32'(DM_enable), 32'h0);
    #5;  chk("reset_im_address_t7", 32'(IM_Address), 32'h0);
         chk("reset_dm_enable_t7", 32'(DM_enable), 32'h0);
    #5;  chk("reset_im_address_t12", 32'(IM_Address), 32'h0);
         chk("reset_dm_enable_t12", 32'(DM_enable), 32'h0);
         chk("reset_dm_address_known", 32'($isunknown(DM_Address)), 32'h0);
         chk("reset_dm_wdata_known", 32'($isunknown(DM_Write_Data)), 32'h0);
    #3;
    load_directed();
    model_reset();
    rst = 1'b1;
    #1;
    run_lockstep(60);

    for (int unsigned k = 0; k < 3; k++)
      chk($sformatf("startup_fetch_%0d", k), trace[k], k);
    foreach (dm_vecs[v])
      chk($sformatf("dm_word_%0d", dm_vecs[v].word), dmem[dm_vecs[v].word], dm_vecs[v].exp);
    check_follow("beq_taken_skip", 30, 33);
    check_follow("bne_not_taken", 33, 34);
    check_follow("bne_taken_skip", 36, 38);
    check_follow("beq_not_taken", 38, 39);
    check_follow("jal_target", 44, 51);
    check_follow("jr_return", 52, 45);
    mx = 0;
    foreach (trace[i]) if (trace[i] > mx) mx = trace[i];
    checks++;
    if (mx <= 54) passed++;
    else $display("FAIL max_im_address: got %0d required at most 54", mx);

    for (int unsigned r = 0; r < 3; r++) begin
      mid_reset();
      gen_random(40);
      model_reset();
      trace.delete();
      @(negedge clk);
      rst = 1'b1;
      #1;
      run_lockstep(50);
      @(negedge clk); #1;
      for (int w = 0; w < 32; w++)
        chk($sformatf("rand%0d_dm_word_%0d", r, w), dmem[w], mdm[w]);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
